render_scan_sequencer: RTL and testbench
========================================

# render_scan_sequencer

Upstream feeder for the rect renderer pipeline. It buffers shape-register writes from the host in a small command FIFO and replays them as program beats. On each frame request it raster-scans the full screen, emitting one pixel coordinate plus background colour per beat. Its outputs drive the renderer's `program_in`/`x`/`y`/`data_in` inputs through a valid/ready handshake.

## Interface
Parameters:
- `H_RES`, 1080, screen width in pixels (x range 0..H_RES-1).
- `V_RES`, 2160, screen height in pixels (y range 0..V_RES-1).
- `FIFO_DEPTH`, 8, command FIFO entries; power of two, ≥2.
- `STRIDE`, 135, scan step; only used under `SCAN_STRIDE_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: host command present.
- `cmd_ready` out 1: FIFO not full; equals `!full`.
- `cmd_addr` in 12: renderer register index; 0 = x pos, 2 = width, 3 = height, 4 = colour.
- `cmd_data` in 32: register value.
- `frame_start` in 1: single-cycle frame request.
- `bg_color` in 32: background colour, sampled when the scan begins.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts the beat.
- `program_out` out 1: 1 = program beat, 0 = pixel beat.
- `x_out` out 11: pixel x; 0 on program beats.
- `y_out` out 12: pixel y, or register index on program beats.
- `data_out` out 32: `cmd_data` on program beats, latched `bg_color` on pixel beats.
- `busy` out 1: state ≠ IDLE, or FIFO non-empty, or a frame is pending.
- `frame_done` out 1: one-cycle pulse after the last pixel is accepted.
- `frame_overrun` out 1: sticky; set by a `frame_start` seen while one is already scanning or pending.

## Operation
- FIFO push: on `cmd_valid && cmd_ready`. Pops occur only in state PROG.
- States:
  - IDLE: if FIFO non-empty → PROG. Else if `frame_start` or `pending` → SCAN. Else stay.
  - PROG: present the head entry (`program_out`=1, x=0, y=`cmd_addr`, data=`cmd_data`). On accept, pop. If the FIFO becomes empty: → SCAN if `pending`, else → IDLE.
  - SCAN: present pixel (x,y). On accept, x += 1. When x = H_RES-1 wraps: x=0, y += 1. Accepting (H_RES-1, V_RES-1) → DONE.
  - DONE: `frame_done`=1 for one cycle, → IDLE.
- `pending`:
  - Set by `frame_start` in IDLE when the FIFO is non-empty, or by `frame_start` during PROG.
  - Cleared on entry to SCAN.
- Commands always complete before a scan; commands arriving during SCAN wait until after DONE.
- `bg_color` is latched into `data_out` on entry to SCAN and held for the whole frame.
- `frame_start` during SCAN, DONE, or with `pending` already set: ignored; sets `frame_overrun`.
- Counter widths: x is 11 bits, y is 12 bits. Compares use `== H_RES-1` and `== V_RES-1`; no counter overflow occurs.

## Timing
- All outputs are registered except `cmd_ready`.
- Reset values: `out_valid`=0, `program_out`=0, `x_out`=0, `y_out`=0, `data_out`=0, `busy`=0, `frame_done`=0, `frame_overrun`=0, FIFO empty (so `cmd_ready`=1), state IDLE, `pending`=0.
- `frame_start` at edge N in IDLE with FIFO empty: pixel (0,0) valid after edge N.
- Throughput is one beat per cycle while `out_ready`=1. A frame takes exactly H_RES×V_RES accepted beats.
- `out_ready`=0: all outputs hold stable; no counter or FIFO change.
- Push into an empty FIFO at edge N: IDLE→PROG at N+1, beat valid after N+1.
- Simultaneous push and pop: allowed; occupancy unchanged. When full, `cmd_ready`=0 regardless of a same-cycle pop.
- `rst_n` low mid-frame or mid-PROG: immediate return to reset values. FIFO contents and `pending` are discarded.

## Configuration
- `SCAN_STRIDE_EN` defined: x and y step by `STRIDE`.
  - A step that reaches or exceeds H_RES wraps x to 0; likewise for y.
  - The last pixel is the final stepped (x,y) below the limits, e.g. (945,2025) for the default parameters.
  - The frame is 8×16 = 128 beats.
- Not defined: unit step, full H_RES×V_RES scan; `STRIDE` is ignored.

## Test plan
- Reset: assert `rst_n`=0 mid-scan → all outputs take reset values asynchronously; after release, `cmd_ready`=1 and `busy`=0.
- Push {2,1080}, {3,2160}, {4,FF000000}, then `frame_start` with `bg_color`=FF0000FF → three program beats in order (y=2,3,4), then pixel (0,0) with data FF0000FF.
- `SCAN_STRIDE_EN`, `out_ready`=1 → exactly 128 pixel beats; last beat is (945,2025); `frame_done` pulses once the cycle after.
- Toggle `out_ready` 0/1 randomly → beat sequence identical to the `out_ready`=1 run; outputs stable while stalled.
- Push 9 commands with `FIFO_DEPTH`=8 and no frame → `cmd_ready`=0 after the 8th push; the 9th is held until the first pop.
- `frame_start` twice during a scan → `frame_overrun`=1, only one frame emitted; a `frame_start` during PROG starts the scan immediately after the last command.

Source files
------------

// File: rtl/render_scan_sequencer.sv
// render_scan_sequencer: buffers host register writes in a small command FIFO,
// replays them as program beats, then raster-scans the screen emitting one
// pixel coordinate plus latched background colour per beat (valid/ready out).
// Optional feature macro: SCAN_STRIDE_EN (x/y step by STRIDE instead of 1).
module render_scan_sequencer #(
  parameter int unsigned H_RES      = 1080,
  parameter int unsigned V_RES      = 2160,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned STRIDE     = 135
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [11:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic        frame_start,
  input  logic [31:0] bg_color,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        program_out,
  output logic [10:0] x_out,
  output logic [11:0] y_out,
  output logic [31:0] data_out,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_overrun
);

  localparam int unsigned XW = 11;
  localparam int unsigned YW = 12;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  // Reject unusable parameterisations at elaboration
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (STRIDE == 0) begin : g_bad_stride
    $error("STRIDE must be non-zero");
  end

  typedef enum logic [1:0] {IDLE, PROG, SCAN, DONE} state_t;

  state_t         state, state_n;
  logic           pending, pending_n;
  logic [11:0]    mem_addr [FIFO_DEPTH];
  logic [31:0]    mem_data [FIFO_DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr, rd_nxt;
  logic [CW-1:0]  count, count_after;
  logic           empty, full, push, pop, accept, start_scan;
  logic           valid_n, prog_n, done_n, overrun_n, busy_n;
  logic [XW-1:0]  x_n, x_step;
  logic [YW-1:0]  y_n, y_step;
  logic [31:0]    data_n;
  logic           x_wrap, y_wrap;

  // FIFO status and handshakes
  always_comb begin
    empty       = (count == '0);
    full        = (count == CW'(FIFO_DEPTH));
    cmd_ready   = !full;
    push        = cmd_valid && !full;
    accept      = out_valid && out_ready;
    pop         = (state == PROG) && accept;
    count_after = CW'(count + CW'(push) - CW'(pop));
    rd_nxt      = AW'(rd_ptr + AW'(1));
  end

`ifdef SCAN_STRIDE_EN
  logic [15:0] x_sum, y_sum;
  // Strided scan position: a step reaching the limit wraps to 0
  always_comb begin
    x_sum  = 16'(x_out) + 16'(STRIDE);
    y_sum  = 16'(y_out) + 16'(STRIDE);
    x_wrap = (x_sum >= 16'(H_RES));
    y_wrap = (y_sum >= 16'(V_RES));
    x_step = XW'(x_sum);
    y_step = YW'(y_sum);
  end
`else
  // Unit-step scan position
  always_comb begin
    x_wrap = (x_out == XW'(H_RES - 1));
    y_wrap = (y_out == YW'(V_RES - 1));
    x_step = XW'(x_out + XW'(1));
    y_step = YW'(y_out + YW'(1));
  end
`endif

  // Next-state and next-output logic
  always_comb begin
    state_n    = state;
    pending_n  = pending;
    valid_n    = out_valid;
    prog_n     = program_out;
    x_n        = x_out;
    y_n        = y_out;
    data_n     = data_out;
    done_n     = 1'b0;
    overrun_n  = frame_overrun;
    start_scan = 1'b0;

    if (frame_start) begin
      if (state == SCAN || state == DONE || pending) overrun_n = 1'b1;
      else if (state == PROG || !empty)               pending_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (!empty) begin
          state_n = PROG;
          valid_n = 1'b1;
          prog_n  = 1'b1;
          x_n     = '0;
          y_n     = mem_addr[rd_ptr];
          data_n  = mem_data[rd_ptr];
        end else if (frame_start || pending) begin
          start_scan = 1'b1;
        end
      end
      PROG: begin
        if (accept) begin
          if (count_after == '0) begin
            if (pending_n) begin
              start_scan = 1'b1;
            end else begin
              state_n = IDLE;
              valid_n = 1'b0;
              prog_n  = 1'b0;
            end
          end else if (count > CW'(1)) begin
            y_n    = mem_addr[rd_nxt];
            data_n = mem_data[rd_nxt];
          end else begin
            // Sole entry popped while a new one is pushed: bypass it
            y_n    = cmd_addr;
            data_n = cmd_data;
          end
        end
      end
      SCAN: begin
        if (accept) begin
          if (x_wrap) begin
            x_n = '0;
            if (y_wrap) begin
              state_n = DONE;
              valid_n = 1'b0;
              done_n  = 1'b1;
            end else begin
              y_n = y_step;
            end
          end else begin
            x_n = x_step;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (start_scan) begin
      state_n   = SCAN;
      pending_n = 1'b0;
      valid_n   = 1'b1;
      prog_n    = 1'b0;
      x_n       = '0;
      y_n       = '0;
      data_n    = bg_color;
    end

    busy_n = (state_n != IDLE) || (count_after != '0) || pending_n;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pending       <= 1'b0;
      out_valid     <= 1'b0;
      program_out   <= 1'b0;
      x_out         <= '0;
      y_out         <= '0;
      data_out      <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      state         <= state_n;
      pending       <= pending_n;
      out_valid     <= valid_n;
      program_out   <= prog_n;
      x_out         <= x_n;
      y_out         <= y_n;
      data_out      <= data_n;
      busy          <= busy_n;
      frame_done    <= done_n;
      frame_overrun <= overrun_n;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= AW'(wr_ptr + AW'(1));
      if (pop)  rd_ptr <= rd_nxt;
      count <= count_after;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= cmd_addr;
      mem_data[wr_ptr] <= cmd_data;
    end
  end

endmodule

// File: tb/tb_render_scan_sequencer.sv
// Randomised bench for render_scan_sequencer on a reduced screen; expected beats
// come from a queue-based model of the command replay and raster order.
module tb_render_scan_sequencer;

  localparam int unsigned H_P = 7;
  localparam int unsigned V_P = 4;
  localparam int unsigned D_P = 8;
  localparam int unsigned S_P = 3;
`ifdef SCAN_STRIDE_EN
  localparam int unsigned TB_STEP = S_P;
`else
  localparam int unsigned TB_STEP = 1;
`endif

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        frame_start;
  logic [31:0] bg_color;
  logic        out_valid, out_ready, program_out;
  logic [10:0] x_out;
  logic [11:0] y_out;
  logic [31:0] data_out;
  logic        busy, frame_done, frame_overrun;

  render_scan_sequencer #(
    .H_RES(H_P), .V_RES(V_P), .FIFO_DEPTH(D_P), .STRIDE(S_P)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .frame_start(frame_start), .bg_color(bg_color),
    .out_valid(out_valid), .out_ready(out_ready), .program_out(program_out),
    .x_out(x_out), .y_out(y_out), .data_out(data_out),
    .busy(busy), .frame_done(frame_done), .frame_overrun(frame_overrun)
  );

  typedef struct {
    logic        prog;
    logic [10:0] x;
    logic [11:0] y;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    ready_mode = 0;
  bit    mon_en = 0;
  int    cyc = 0;
  int    last_prog_cyc = 0;
  int    first_pix_cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // out_ready driver: held low, held high, or random per cycle
  initial begin
    out_ready = 0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: beat order, stall stability, frame_done timing
  initial begin
    bit          done_due = 0;
    bit          prev_stall = 0;
    logic [56:0] prev_vec = '0;
    beat_t       e;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en && rst_n) begin
        check_eq("frame_done", 64'(frame_done), 64'(done_due));
        done_due = 0;
        if (prev_stall)
          check_eq("stall_hold", 64'({out_valid, program_out, x_out, y_out, data_out}), 64'(prev_vec));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_beat", 64'({program_out, x_out, y_out, data_out}), 64'hDEAD);
          end else begin
            e = exp_q.pop_front();
            check_eq("beat", 64'({program_out, x_out, y_out, data_out}),
                     64'({e.prog, e.x, e.y, e.data}));
            done_due = e.last;
            if (program_out) last_prog_cyc = cyc;
            else if (x_out == 0 && y_out == 0) first_pix_cyc = cyc;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_vec   = {out_valid, program_out, x_out, y_out, data_out};
      end else begin
        done_due   = 0;
        prev_stall = 0;
      end
    end
  end

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_valid"},   64'(out_valid), 0);
    check_eq({pfx, "_prog"},    64'(program_out), 0);
    check_eq({pfx, "_x"},       64'(x_out), 0);
    check_eq({pfx, "_y"},       64'(y_out), 0);
    check_eq({pfx, "_data"},    64'(data_out), 0);
    check_eq({pfx, "_busy"},    64'(busy), 0);
    check_eq({pfx, "_done"},    64'(frame_done), 0);
    check_eq({pfx, "_overrun"}, 64'(frame_overrun), 0);
    check_eq({pfx, "_ready"},   64'(cmd_ready), 1);
  endtask

  task automatic push_cmd(input logic [11:0] a, input logic [31:0] d);
    beat_t b;
    int    n = 0;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("push_accept", 64'(cmd_ready), 1);
    b.prog = 1; b.x = '0; b.y = a; b.data = d; b.last = 0;
    exp_q.push_back(b);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic add_frame(input logic [31:0] bg);
    beat_t b;
    for (int y = 0; y < int'(V_P); y += int'(TB_STEP))
      for (int x = 0; x < int'(H_P); x += int'(TB_STEP)) begin
        b.prog = 0; b.x = 11'(x); b.y = 12'(y); b.data = bg; b.last = 0;
        exp_q.push_back(b);
      end
    b = exp_q.pop_back();
    b.last = 1;
    exp_q.push_back(b);
  endtask

  task automatic pulse_frame();
    frame_start = 1;
    @(posedge clk); #1;
    frame_start = 0;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 64'(exp_q.size() == 0 && !busy), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [11:0] a9;
    logic [31:0] d9, bg;
    rst_n = 0; cmd_valid = 0; cmd_addr = 0; cmd_data = 0;
    frame_start = 0; bg_color = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("init");
    rst_n = 1;
    mon_en = 1;

    // Program three shape registers, then a frame
    ready_mode = 1;
    push_cmd(12'd2, 32'd1080);
    push_cmd(12'd3, 32'd2160);
    push_cmd(12'd4, 32'hFF000000);
    bg_color = 32'hFF0000FF;
    add_frame(32'hFF0000FF);
    pulse_frame();
    drain(500);
    check_eq("overrun_after_prog", 64'(frame_overrun), 0);

    // frame_start during PROG: scan follows the last command directly
    ready_mode = 0;
    @(posedge clk); #1;
    push_cmd(12'($urandom), $urandom);
    push_cmd(12'($urandom), $urandom);
    bg = $urandom;
    bg_color = bg;
    add_frame(bg);
    pulse_frame();
    check_eq("pending_busy", 64'(busy), 1);
    ready_mode = 1;
    drain(500);
    check_eq("prog_to_scan_gap", 64'(first_pix_cyc - last_prog_cyc), 1);

    // Fill the FIFO with no frame; 9th command held until the first pop
    ready_mode = 0;
    @(posedge clk); #1;
    for (int i = 0; i < int'(D_P); i++) push_cmd(12'($urandom), $urandom);
    @(negedge clk);
    check_eq("full_ready", 64'(cmd_ready), 0);
    a9 = 12'($urandom);
    d9 = $urandom;
    cmd_addr = a9; cmd_data = d9; cmd_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("held_while_full", 64'(cmd_ready), 0);
    end
    ready_mode = 2;
    push_cmd(a9, d9);
    drain(1000);

    // Frame from IDLE: first pixel right after the sampling edge; overrun
    check_eq("overrun_clear", 64'(frame_overrun), 0);
    ready_mode = 0;
    @(posedge clk); #1;
    bg = $urandom;
    bg_color = bg;
    add_frame(bg);
    pulse_frame();
    check_eq("first_valid", 64'(out_valid), 1);
    check_eq("first_prog",  64'(program_out), 0);
    check_eq("first_xy",    64'({x_out, y_out}), 0);
    check_eq("first_data",  64'(data_out), 64'(bg));
    bg_color = ~bg;
    ready_mode = 2;
    repeat (4) @(posedge clk);
    #1;
    pulse_frame();
    @(negedge clk);
    check_eq("overrun_set", 64'(frame_overrun), 1);
    repeat (3) @(posedge clk);
    #1;
    pulse_frame();
    drain(2000);
    repeat (5) @(posedge clk);
    #1;
    check_eq("overrun_sticky", 64'(frame_overrun), 1);
    check_eq("single_frame_idle", 64'(busy), 0);

    // Asynchronous reset mid-scan
    bg = $urandom;
    bg_color = bg;
    add_frame(bg);
    pulse_frame();
    repeat (10) @(posedge clk);
    #2;
    mon_en = 0;
    rst_n = 0;
    #1;
    check_reset_vals("rst_scan");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    check_eq("post_rst_ready", 64'(cmd_ready), 1);
    check_eq("post_rst_busy",  64'(busy), 0);

    // Reset mid-PROG discards queued commands
    mon_en = 1;
    ready_mode = 0;
    @(posedge clk); #1;
    push_cmd(12'($urandom), $urandom);
    push_cmd(12'($urandom), $urandom);
    @(posedge clk); #2;
    mon_en = 0;
    rst_n = 0;
    #1;
    check_reset_vals("rst_prog");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1;
    mon_en = 1;
    ready_mode = 1;
    repeat (20) @(negedge clk);
    check_eq("flushed_busy",  64'(busy), 0);
    check_eq("flushed_valid", 64'(out_valid), 0);
    check_eq("flushed_ready", 64'(cmd_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
